// File: rtl/instr_register_alu_pkg.sv
// rtl/instr_register_alu_pkg.sv - shared opcode/result types and default sizes for the instruction register stack.
package instr_register_pkg;

  localparam int OP_WIDTH_DEF = 32;
  localparam int DEPTH_DEF    = 32;

  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t                            opc;
    logic signed [OP_WIDTH_DEF-1:0]     op_a;
    logic        [OP_WIDTH_DEF-1:0]     op_b;
    logic signed [2*OP_WIDTH_DEF-1:0]   result;
  } instr_result_t;

endpackage

// File: rtl/instr_register_alu_if.sv
// rtl/instr_register_alu_if.sv - write/read bus of the instruction register stack; div_err exists only with IREG_DIVZERO_ERR_EN.
interface instr_register_alu_if
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF
) ();
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    opcode_t                        opc;
    logic signed [OP_WIDTH-1:0]     op_a;
    logic        [OP_WIDTH-1:0]     op_b;
    logic signed [2*OP_WIDTH-1:0]   result;
  } word_t;

  logic                        load_en;
  logic [AW-1:0]               write_pointer;
  opcode_t                     opcode;
  logic signed [OP_WIDTH-1:0]  operand_a;
  logic [OP_WIDTH-1:0]         operand_b;
  logic [AW-1:0]               read_pointer;
  word_t                       instruction_word;
  logic                        read_valid;
  logic [AW:0]                 valid_count;
  logic                        full;
`ifdef IREG_DIVZERO_ERR_EN
  logic                        div_err;
`endif

  modport master (
    output load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
    input  instruction_word, read_valid, valid_count, full
`ifdef IREG_DIVZERO_ERR_EN
    , input div_err
`endif
  );

  modport slave (
    input  load_en, write_pointer, opcode, operand_a, operand_b, read_pointer,
    output instruction_word, read_valid, valid_count, full
`ifdef IREG_DIVZERO_ERR_EN
    , output div_err
`endif
  );

endinterface

// File: rtl/instr_register_alu_exec_unit.sv
// rtl/instr_register_alu_exec_unit.sv - combinational opcode evaluator producing a double-width signed result and a fault flag.
module instr_exec_unit
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF
) (
  input  opcode_t                      opcode_i,
  input  logic signed [OP_WIDTH-1:0]   op_a_i,
  input  logic [OP_WIDTH-1:0]          op_b_i,
  output logic signed [2*OP_WIDTH-1:0] result_o,
  output logic                         fault_o
);
  localparam int RW = 2 * OP_WIDTH;

  logic signed [RW-1:0] a_ext;
  logic signed [RW-1:0] b_ext;
  logic                 b_zero;

  // Both operands widen to 2*OP_WIDTH signed so every op, including the full product, is exact.
  always_comb begin
    a_ext    = {{OP_WIDTH{op_a_i[OP_WIDTH-1]}}, op_a_i};
    b_ext    = {{OP_WIDTH{1'b0}}, op_b_i};
    b_zero   = (op_b_i == '0);
    result_o = '0;
    fault_o  = 1'b0;
    case (opcode_i)
      ZERO:  result_o = '0;
      PASSA: result_o = a_ext;
      PASSB: result_o = b_ext;
      ADD:   result_o = a_ext + b_ext;
      SUB:   result_o = a_ext - b_ext;
      MULT:  result_o = a_ext * b_ext;
      DIV: begin
        if (b_zero) fault_o  = 1'b1;
        else        result_o = a_ext / b_ext;
      end
      MOD: begin
        if (b_zero) fault_o  = 1'b1;
        else        result_o = a_ext % b_ext;
      end
      default: fault_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_register_alu.sv
// rtl/instr_register_alu.sv - DEPTH-entry instruction/result stack with registered write-first reads; IREG_DIVZERO_ERR_EN adds sticky div_err.
module instr_register_alu
  import instr_register_pkg::*;
#(
  parameter int OP_WIDTH = OP_WIDTH_DEF,
  parameter int DEPTH    = DEPTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  instr_register_alu_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    opcode_t                        opc;
    logic signed [OP_WIDTH-1:0]     op_a;
    logic        [OP_WIDTH-1:0]     op_b;
    logic signed [2*OP_WIDTH-1:0]   result;
  } word_t;

  word_t                        mem_q [DEPTH];
  logic [DEPTH-1:0]             valid_q;
  word_t                        rd_word_q, rd_word_d;
  logic                         rd_valid_q, rd_valid_d;
  logic [AW:0]                  count_q, count_d;
  logic                         full_q, full_d;
  word_t                        wr_word;
  logic                         collision;
  logic                         new_entry;
  logic signed [2*OP_WIDTH-1:0] exec_result;
`ifdef IREG_DIVZERO_ERR_EN
  logic                         exec_fault;
  logic                         div_err_q;
`else
  logic                         exec_fault_unused;
`endif

  instr_exec_unit #(.OP_WIDTH(OP_WIDTH)) u_exec (
    .opcode_i (bus.opcode),
    .op_a_i   (bus.operand_a),
    .op_b_i   (bus.operand_b),
    .result_o (exec_result),
`ifdef IREG_DIVZERO_ERR_EN
    .fault_o  (exec_fault)
`else
    .fault_o  (exec_fault_unused)
`endif
  );

  always_comb begin
    wr_word    = '{opc: bus.opcode, op_a: bus.operand_a, op_b: bus.operand_b, result: exec_result};
    collision  = bus.load_en && (bus.read_pointer == bus.write_pointer);
    new_entry  = bus.load_en && !valid_q[bus.write_pointer];
    rd_word_d  = collision ? wr_word : mem_q[bus.read_pointer];
    rd_valid_d = collision || valid_q[bus.read_pointer];
    count_d    = count_q + {{AW{1'b0}}, new_entry};
    full_d     = (count_d == (AW+1)'(DEPTH));
  end

  // Payload storage has no reset; the valid bits alone decide what is meaningful.
  always_ff @(posedge clk) begin
    if (bus.load_en && !reset) mem_q[bus.write_pointer] <= wr_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q    <= '0;
      rd_word_q  <= '0;
      rd_valid_q <= 1'b0;
      count_q    <= '0;
      full_q     <= 1'b0;
    end else begin
      if (bus.load_en) valid_q[bus.write_pointer] <= 1'b1;
      rd_word_q  <= rd_word_d;
      rd_valid_q <= rd_valid_d;
      count_q    <= count_d;
      full_q     <= full_d;
    end
  end

`ifdef IREG_DIVZERO_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_err_q <= 1'b0;
    else if (bus.load_en && exec_fault) div_err_q <= 1'b1;
  end
  assign bus.div_err = div_err_q;
`endif

  assign bus.instruction_word = rd_word_q;
  assign bus.read_valid       = rd_valid_q;
  assign bus.valid_count      = count_q;
  assign bus.full             = full_q;

endmodule

// File: tb/tb_instr_register_alu.sv
// tb/tb_instr_register_alu.sv - directed self-checking bench for instr_register_alu; div_err checks follow IREG_DIVZERO_ERR_EN.
module tb_instr_register_alu;
  import instr_register_pkg::*;

  logic clk;
  logic reset;
  int   n_chk;
  int   n_err;

  instr_register_alu_if #(.OP_WIDTH(32), .DEPTH(32)) bus ();

  instr_register_alu #(.OP_WIDTH(32), .DEPTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [4:0] p, input opcode_t o, input logic [31:0] a, input logic [31:0] b);
    bus.load_en       = 1'b1;
    bus.write_pointer = p;
    bus.opcode        = o;
    bus.operand_a     = a;
    bus.operand_b     = b;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic rd(input logic [4:0] p);
    bus.read_pointer = p;
    @(negedge clk);
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b1;
    bus.load_en = 1'b0;
    bus.write_pointer = '0;
    bus.opcode = ZERO;
    bus.operand_a = '0;
    bus.operand_b = '0;
    bus.read_pointer = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_word_zero", 64'(bus.instruction_word === '0), 64'd1);
    chk("rst_read_valid", 64'(bus.read_valid), 64'd0);
    chk("rst_count", 64'(bus.valid_count), 64'd0);
    chk("rst_full", 64'(bus.full), 64'd0);
`ifdef IREG_DIVZERO_ERR_EN
    chk("rst_div_err", 64'(bus.div_err), 64'd0);
`endif
    rd(0);
    chk("empty_read_valid", 64'(bus.read_valid), 64'd0);

    wr(0, ADD, -32'sd5, 32'd7);
    rd(0);
    chk("add_result", bus.instruction_word.result, 64'd2);
    chk("add_opc", 64'(bus.instruction_word.opc), 64'(ADD));
    chk("add_read_valid", 64'(bus.read_valid), 64'd1);
    chk("add_count", 64'(bus.valid_count), 64'd1);

    wr(3, DIV, -32'sd7, 32'd2);
    wr(4, MOD, -32'sd7, 32'd2);
    wr(5, MULT, 32'h7FFF_FFFF, 32'hFFFF_FFFF);
    rd(3);
    chk("div_neg", bus.instruction_word.result, 64'hFFFF_FFFF_FFFF_FFFD);
    rd(4);
    chk("mod_neg", bus.instruction_word.result, 64'hFFFF_FFFF_FFFF_FFFF);
    rd(5);
    chk("mult_full", bus.instruction_word.result, 64'h7FFF_FFFE_8000_0001);
    chk("count_4", 64'(bus.valid_count), 64'd4);

    bus.read_pointer = 5'd9;
    wr(9, SUB, 32'd10, 32'd3);
    chk("coll_sub", bus.instruction_word.result, 64'd7);
    chk("coll_read_valid", 64'(bus.read_valid), 64'd1);
    chk("coll_count", 64'(bus.valid_count), 64'd5);
    wr(9, SUB, 32'd20, 32'd3);
    chk("rewrite_sub", bus.instruction_word.result, 64'd17);
    chk("rewrite_count", 64'(bus.valid_count), 64'd5);
    rd(10);
    chk("unwritten_valid", 64'(bus.read_valid), 64'd0);

    for (int i = 0; i < 31; i++) wr(5'(i), PASSB, 32'd0, 32'(i));
    chk("count_31", 64'(bus.valid_count), 64'd31);
    chk("not_full_31", 64'(bus.full), 64'd0);
    wr(31, PASSB, 32'd0, 32'd31);
    chk("count_32", 64'(bus.valid_count), 64'd32);
    chk("full_32", 64'(bus.full), 64'd1);
    rd(7);
    chk("passb_7", bus.instruction_word.result, 64'd7);

    wr(6, PASSA, 32'hFFFF_FFFF, 32'd0);
    rd(6);
    chk("passa_sext", bus.instruction_word.result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("overwrite_count", 64'(bus.valid_count), 64'd32);
`ifdef IREG_DIVZERO_ERR_EN
    chk("div_err_clear", 64'(bus.div_err), 64'd0);
`endif

    wr(1, DIV, 32'd4, 32'd0);
    rd(1);
    chk("div0_result", bus.instruction_word.result, 64'd0);
    chk("div0_valid", 64'(bus.read_valid), 64'd1);
    chk("div0_full", 64'(bus.full), 64'd1);
`ifdef IREG_DIVZERO_ERR_EN
    chk("div0_err", 64'(bus.div_err), 64'd1);
`endif

    wr(8, opcode_t'(4'd12), 32'd5, 32'd5);
    rd(8);
    chk("badop_result", bus.instruction_word.result, 64'd0);
    chk("badop_opc", 64'(bus.instruction_word.opc), 64'd12);
    chk("badop_valid", 64'(bus.read_valid), 64'd1);

    bus.load_en = 1'b1;
    bus.write_pointer = 5'd2;
    bus.read_pointer = 5'd2;
    bus.opcode = ADD;
    bus.operand_a = 32'd1;
    bus.operand_b = 32'd1;
    #2 reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(bus.valid_count), 64'd0);
    chk("async_rst_full", 64'(bus.full), 64'd0);
    chk("async_rst_valid", 64'(bus.read_valid), 64'd0);
    chk("async_rst_word", 64'(bus.instruction_word === '0), 64'd1);
`ifdef IREG_DIVZERO_ERR_EN
    chk("async_rst_div_err", 64'(bus.div_err), 64'd0);
`endif
    @(negedge clk);
    chk("rst_write_lost", 64'(bus.valid_count), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    bus.load_en = 1'b0;
    chk("post_rst_write_count", 64'(bus.valid_count), 64'd1);
    chk("post_rst_write_result", bus.instruction_word.result, 64'd2);
    rd(3);
    chk("post_rst_cleared", 64'(bus.read_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
